// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the core MEM stage
// (port C) and a loader/debug DMA (port L). Round-robin arbitration with a
// bounded locked-burst mode for the loader, Mealy grant/stall, 1-cycle reads.
module dmem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_stall,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    input  logic              i_l_lock,
    output logic              o_l_gnt,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic              o_m_MemRead,
    output logic              o_m_MemWrite,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_m_rdata
);

    localparam int                CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic {
        MODE_SHARE  = 1'b0,
        MODE_LOCKED = 1'b1
    } mode_t;

    mode_t             r_mode;
    mode_t             w_mode_nxt;
    logic              r_last;        // last granted port: 0 = C, 1 = L
    logic              w_last_nxt;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic [CNT_W-1:0]  w_lock_cnt_nxt;

    logic              w_c_gnt;
    logic              w_l_gnt;
    logic              w_c_rd;
    logic              w_l_rd;

    // read-return stage: owner/flag plus one data register per port so the
    // port that is not being returned to keeps its last read data
    logic              r_rpend_p1;
    logic              r_rsel_p1;     // 0 = C, 1 = L
    logic [DATA_W-1:0] r_c_rdata_p1;
    logic [DATA_W-1:0] r_l_rdata_p1;

    // Arbitration state register: mode, last winner, locked-burst counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mode     <= MODE_SHARE;
            r_last     <= 1'b1;       // core wins the first contention
            r_lock_cnt <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Next-state: a locked loader grant extends the burst, anything else drops back to sharing
    always_comb begin
        w_mode_nxt     = MODE_SHARE;
        w_lock_cnt_nxt = '0;
        w_last_nxt     = r_last;
        if (w_c_gnt) begin
            w_last_nxt = 1'b0;
        end else if (w_l_gnt) begin
            w_last_nxt = 1'b1;
        end
        if (w_l_gnt && i_l_lock && i_l_req) begin
            w_mode_nxt = MODE_LOCKED;
            if (i_c_req) begin
                // saturate so a long burst never wraps back to starving the core
                w_lock_cnt_nxt = (r_lock_cnt == CNT_MAX) ? CNT_MAX
                                                         : r_lock_cnt + CNT_W'(1);
            end
        end
    end

    // Grant decode (Mealy); everything is masked while reset is held
    always_comb begin
        w_c_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!i_reset) begin
            if (i_c_req && i_l_req) begin
                if (r_mode == MODE_LOCKED) begin
                    if (r_lock_cnt < CNT_MAX) begin
                        w_l_gnt = 1'b1;
                    end else begin
                        w_c_gnt = 1'b1;
                    end
                end else if (r_last) begin
                    w_c_gnt = 1'b1;
                end else begin
                    w_l_gnt = 1'b1;
                end
            end else if (i_c_req) begin
                w_c_gnt = 1'b1;
            end else if (i_l_req) begin
                w_l_gnt = 1'b1;
            end
        end
    end

    // Memory pin mux: the winner's request goes out, idle pins are driven to zero
    always_comb begin
        o_m_MemRead  = 1'b0;
        o_m_MemWrite = 1'b0;
        o_m_addr     = '0;
        o_m_wdata    = '0;
        if (w_c_gnt) begin
            o_m_MemRead  = ~i_c_we;
            o_m_MemWrite = i_c_we;
            o_m_addr     = i_c_addr;
            o_m_wdata    = i_c_wdata;
        end else if (w_l_gnt) begin
            o_m_MemRead  = ~i_l_we;
            o_m_MemWrite = i_l_we;
            o_m_addr     = i_l_addr;
            o_m_wdata    = i_l_wdata;
        end
    end

    assign w_c_rd = w_c_gnt & ~i_c_we;
    assign w_l_rd = w_l_gnt & ~i_l_we;

    // Read-return stage boundary: capture memory data for the granted reader
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rpend_p1   <= 1'b0;
            r_rsel_p1    <= 1'b0;
            r_c_rdata_p1 <= '0;
            r_l_rdata_p1 <= '0;
        end else begin
            r_rpend_p1 <= w_c_rd | w_l_rd;
            if (w_c_rd) begin
                r_rsel_p1    <= 1'b0;
                r_c_rdata_p1 <= i_m_rdata;
            end else if (w_l_rd) begin
                r_rsel_p1    <= 1'b1;
                r_l_rdata_p1 <= i_m_rdata;
            end
        end
    end

    assign o_c_gnt    = w_c_gnt;
    assign o_l_gnt    = w_l_gnt;
    assign o_c_stall  = i_c_req & ~w_c_gnt & ~i_reset;
    assign o_c_rvalid = r_rpend_p1 & ~r_rsel_p1;
    assign o_l_rvalid = r_rpend_p1 & r_rsel_p1;
    assign o_c_rdata  = r_c_rdata_p1;
    assign o_l_rdata  = r_l_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against a small behavioural data memory.
module tb_dmem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, c_gnt, c_stall, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          m_MemRead, m_MemWrite;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [DW-1:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_stall(c_stall), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .i_l_lock(l_lock), .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_m_MemRead(m_MemRead), .o_m_MemWrite(m_MemWrite), .o_m_addr(m_addr),
        .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr[7:0]];

    always @(posedge clk) begin
        if (m_MemWrite) mem[m_addr[7:0]] <= m_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic ec, input logic el);
        chk({tag, "_cgnt"}, c_gnt, ec);
        chk({tag, "_lgnt"}, l_gnt, el);
        chk({tag, "_stall"}, c_stall, c_req & ~ec);
    endtask

    task automatic chk_rd(input string tag, input logic ecv, input logic elv,
                          input logic [63:0] edata);
        chk({tag, "_crv"}, c_rvalid, ecv);
        chk({tag, "_lrv"}, l_rvalid, elv);
        if (ecv) chk({tag, "_crd"}, c_rdata, edata);
        if (elv) chk({tag, "_lrd"}, l_rdata, edata);
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;
    endtask

    // drive at the falling edge, sample 1 time unit later
    task automatic step();
        @(negedge clk);
    endtask

    logic [AW-1:0] c_ptr, l_ptr;
    logic          pv_c, pv_l;
    logic [DW-1:0] pv_d;
    logic          exp_l;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 64'h1000 + 64'(i);
        mem[8'h10] <= 64'hDEAD;
        mem[8'h20] <= 64'h77;
        idle();
        reset = 1;
        #2;
        chk("rst_cgnt", c_gnt, 0);
        chk("rst_lgnt", l_gnt, 0);
        chk("rst_crv", c_rvalid, 0);
        chk("rst_lrv", l_rvalid, 0);
        chk("rst_crd", c_rdata, 0);
        chk("rst_lrd", l_rdata, 0);
        // requests during reset must not reach the memory
        c_req = 1; c_addr = 64'h10; l_req = 1; l_addr = 64'h11;
        #1;
        chk("rst_mrd", m_MemRead, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_cgnt_req", c_gnt, 0);
        chk("rst_lgnt_req", l_gnt, 0);
        chk("rst_stall", c_stall, 0);
        step(); step();
        reset = 0;

        // first contention after reset: core wins, then loader
        c_req = 1; c_addr = 64'h10; l_req = 1; l_addr = 64'h11;
        #1;
        chk_gnt("first", 1, 0);
        chk("first_mrd", m_MemRead, 1);
        chk("first_maddr", m_addr, 64'h10);
        step();
        c_addr = 64'h12;
        #1;
        chk_gnt("second", 0, 1);
        chk("second_maddr", m_addr, 64'h11);
        chk_rd("second", 1, 0, 64'hDEAD);
        step();
        l_req = 0;
        #1;
        chk_gnt("third", 1, 0);
        chk_rd("third", 0, 1, 64'h1011);
        chk("third_crd_hold", c_rdata, 64'hDEAD);
        step();
        idle();
        #1;
        chk_gnt("idle", 0, 0);
        chk("idle_mrd", m_MemRead, 0);
        chk("idle_maddr", m_addr, 0);
        chk_rd("idle", 1, 0, 64'h1012);

        // alternation without lock; last = C so loader goes first
        c_ptr = 64'h30; l_ptr = 64'h40;
        pv_c = 0; pv_l = 0; pv_d = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            c_req = 1; c_addr = c_ptr; l_req = 1; l_addr = l_ptr;
            #1;
            exp_l = (k % 2 == 0);
            chk_gnt($sformatf("alt%0d", k), !exp_l, exp_l);
            if (k > 0) chk_rd($sformatf("alt%0d", k), pv_c, pv_l, pv_d);
            pv_c = !exp_l; pv_l = exp_l;
            pv_d = exp_l ? (64'h1000 + l_ptr) : (64'h1000 + c_ptr);
            if (exp_l) l_ptr = l_ptr + 1; else c_ptr = c_ptr + 1;
        end

        // loader write vs core read to the same address, last = C
        step();
        c_req = 1; c_we = 0; c_addr = 64'h20;
        l_req = 1; l_we = 1; l_addr = 64'h20; l_wdata = 64'h55;
        #1;
        chk_rd("alt_last", pv_c, pv_l, pv_d);
        chk_gnt("coll_w", 0, 1);
        chk("coll_mwr", m_MemWrite, 1);
        chk("coll_mrd", m_MemRead, 0);
        chk("coll_mwd", m_wdata, 64'h55);
        step();
        l_req = 0; l_we = 0; l_wdata = '0; l_addr = '0;
        #1;
        chk_gnt("coll_r", 1, 0);
        chk("coll_r_mrd", m_MemRead, 1);
        chk_rd("coll_r", 0, 0, 0);
        step();
        idle();
        #1;
        chk_rd("coll_done", 1, 0, 64'h55);

        // locked burst: 8 loader grants, one core grant, loader again
        for (int k = 0; k < 10; k++) begin
            step();
            c_req = 1; c_addr = 64'h50; l_req = 1; l_lock = 1; l_addr = 64'h60;
            #1;
            exp_l = (k != LM);
            chk_gnt($sformatf("lock%0d", k), !exp_l, exp_l);
        end
        step();
        idle();
        #1;
        chk_rd("lock_end", 0, 1, 64'h1060);
        chk("lock_crd", c_rdata, 64'h1050);

        // reset hits while a core read is granted
        step();
        c_req = 1; c_addr = 64'h10;
        #1;
        chk_gnt("prerst", 1, 0);
        #2;
        reset = 1;
        #1;
        chk("rst2_crv", c_rvalid, 0);
        chk("rst2_crd", c_rdata, 0);
        chk("rst2_mrd", m_MemRead, 0);
        step();
        #1;
        chk("rst2_crv_b", c_rvalid, 0);
        step();
        idle();
        reset = 0;
        #1;
        chk_rd("post_rst", 0, 0, 0);
        chk("post_rst_crd", c_rdata, 0);
        step();
        #1;
        chk_rd("post_rst2", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
